// File: rtl/spi_sd_responder_pkg.sv
// Shared constants for the SPI-mode SD card model: R1 bit positions,
// command indices, frame length and FSM state encoding.
package spi_sd_responder_pkg;

  localparam int unsigned R1_IDLE    = 0;
  localparam int unsigned R1_ILLEGAL = 2;
  localparam int unsigned R1_CRC_ERR = 3;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD1  = 6'd1;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  localparam logic [6:0] FRAME_LEN = 7'd48;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DELAY,
    S_RESP
  } state_t;

endpackage

// File: rtl/spi_sd_responder_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1). clear_i together with en_i restarts the
// sum and folds in the first bit in the same cycle.
module crc7_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] base;
  logic [6:0] crc_d;
  logic       fb;

  always_comb begin
    base  = clear_i ? '0 : crc_q;
    fb    = din_i ^ base[6];
    crc_d = {base[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc_d;
    end else if (clear_i) begin
      crc_q <= '0;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/spi_sd_responder.sv
// SD card emulator in SPI mode 0: oversamples the SPI pins on clk, decodes
// 48-bit command frames and answers with R1 after RESP_DELAY filler bytes.
module spi_sd_responder
  import spi_sd_responder_pkg::*;
#(
  parameter int unsigned RESP_DELAY = 1,
  parameter bit          CHECK_CRC  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SD_CLK,
  input  logic        SD_MOSI,
  input  logic        SD_CS,
  output logic        SD_MISO,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_idle,
  output logic        frame_err
);

  localparam logic [6:0] DELAY_FALLS = 7'(RESP_DELAY * 8);

  logic [2:0]  sclk_s_q;
  logic [1:0]  mosi_s_q, cs_s_q;
  logic        rise, fall, mosi, cs;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [46:0] shift_q, shift_d;
  logic [7:0]  r1_q, r1_d;
  logic        miso_q, miso_d;
  logic        idle_q, idle_d;
  logic        app_q, app_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  logic        crc_clr, crc_en;
  logic [6:0]  crc;
  logic [47:0] frame;
  logic        crc_bad;

  crc7_serial u_crc (
    .clk    (clk),
    .rst_n  (reset_n),
    .clear_i(crc_clr),
    .en_i   (crc_en),
    .din_i  (mosi),
    .crc_o  (crc)
  );

  assign mosi    = mosi_s_q[1];
  assign cs      = cs_s_q[1];
  assign rise    = sclk_s_q[1] & ~sclk_s_q[2];
  assign fall    = ~sclk_s_q[1] & sclk_s_q[2];
  assign frame   = {shift_q, mosi};
  assign crc_bad = CHECK_CRC && (frame[7:1] != crc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s_q <= '0;
      mosi_s_q <= '1;
      cs_s_q   <= '1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      r1_q     <= '1;
      miso_q   <= 1'b1;
      idle_q   <= 1'b1;
      app_q    <= 1'b0;
      idx_q    <= '0;
      arg_q    <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sclk_s_q <= {sclk_s_q[1:0], SD_CLK};
      mosi_s_q <= {mosi_s_q[0], SD_MOSI};
      cs_s_q   <= {cs_s_q[0], SD_CS};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      r1_q     <= r1_d;
      miso_q   <= miso_d;
      idle_q   <= idle_d;
      app_q    <= app_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    r1_d    = r1_q;
    miso_d  = miso_q;
    idle_d  = idle_q;
    app_d   = app_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;

    if (cs) begin
      state_d = S_IDLE;
      miso_d  = 1'b1;
      cnt_d   = '0;
      if (state_q == S_RECV) ferr_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise && !mosi) begin
            shift_d = '0;
            cnt_d   = 7'd1;
            crc_clr = 1'b1;
            crc_en  = 1'b1;
            state_d = S_RECV;
          end
        end
        S_RECV: begin
          if (rise) begin
            shift_d = frame[46:0];
            cnt_d   = cnt_q + 7'd1;
            crc_en  = (cnt_q < 7'd40);
            if (cnt_q == FRAME_LEN - 7'd1) begin
              cnt_d = '0;
              if (!frame[46] || !frame[0]) begin
                ferr_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                idx_d   = frame[45:40];
                arg_d   = frame[39:8];
                valid_d = 1'b1;
                state_d = S_DELAY;
                r1_d    = '0;
                if (crc_bad) begin
                  // Bad CRC reports the error but leaves idle/app state untouched.
                  r1_d[R1_CRC_ERR] = 1'b1;
                  r1_d[R1_IDLE]    = idle_q;
                end else begin
                  app_d = 1'b0;
                  case (frame[45:40])
                    CMD0:  idle_d = 1'b1;
                    CMD1:  idle_d = 1'b0;
                    CMD41: begin
                      if (app_q) idle_d = 1'b0;
                      else begin
                        r1_d[R1_ILLEGAL] = 1'b1;
                        r1_d[R1_IDLE]    = idle_q;
                      end
                    end
                    CMD55: begin
                      app_d         = 1'b1;
                      r1_d[R1_IDLE] = idle_q;
                    end
                    CMD8:  r1_d[R1_IDLE] = idle_q;
                    default: begin
                      r1_d[R1_ILLEGAL] = 1'b1;
                      r1_d[R1_IDLE]    = idle_q;
                    end
                  endcase
                  if (frame[45:40] == CMD0) r1_d[R1_IDLE] = 1'b1;
                end
              end
            end
          end
        end
        S_DELAY: begin
          if (fall) begin
            miso_d = 1'b1;
            if (cnt_q == DELAY_FALLS - 7'd1) begin
              cnt_d   = '0;
              state_d = S_RESP;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        S_RESP: begin
          if (fall) begin
            if (cnt_q[3]) begin
              miso_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              miso_d = r1_q[3'd7 - cnt_q[2:0]];
              cnt_d  = cnt_q + 7'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign SD_MISO   = miso_q;
  assign cmd_valid = valid_q;
  assign cmd_index = idx_q;
  assign cmd_arg   = arg_q;
  assign card_idle = idle_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_sd_responder.sv
// Scoreboard bench: two card models (CRC checked, RESP_DELAY=1; CRC ignored,
// RESP_DELAY=2) share one host; monitors decode cmd_valid and R1 bytes.
module tb_spi_sd_responder;

  localparam time HALF = 80ns;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_clk = 1'b0;
  logic        sd_mosi = 1'b1;
  logic        sd_cs = 1'b1;

  logic        miso_a, valid_a, idle_a, ferr_a;
  logic [5:0]  index_a;
  logic [31:0] arg_a;
  logic        miso_b, valid_b, idle_b, ferr_b;
  logic [5:0]  index_b;
  logic [31:0] arg_b;

  int n_cmp = 0;
  int n_err = 0;
  int n_ferr = 0;
  int host_rises = 0;
  int end_rise = 0;
  int rst_epoch = 0;

  logic [38:0] q_cmd[$];
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];

  always #5ns clk = ~clk;

  spi_sd_responder #(.RESP_DELAY(1), .CHECK_CRC(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .SD_CLK(sd_clk), .SD_MOSI(sd_mosi), .SD_CS(sd_cs),
    .SD_MISO(miso_a), .cmd_valid(valid_a), .cmd_index(index_a), .cmd_arg(arg_a),
    .card_idle(idle_a), .frame_err(ferr_a)
  );

  spi_sd_responder #(.RESP_DELAY(2), .CHECK_CRC(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .SD_CLK(sd_clk), .SD_MOSI(sd_mosi), .SD_CS(sd_cs),
    .SD_MISO(miso_b), .cmd_valid(valid_b), .cmd_index(index_b), .cmd_arg(arg_b),
    .card_idle(idle_b), .frame_err(ferr_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // cmd_valid monitor for card A
  always @(negedge clk) begin
    logic [38:0] e;
    if (valid_a) begin
      if (q_cmd.size() == 0) begin
        check("unexpected cmd_valid", 64'(index_a), 64'hFFFF);
      end else begin
        e = q_cmd.pop_front();
        check("cmd_index", 64'(index_a), 64'(e[37:32]));
        check("cmd_arg", 64'(arg_a), 64'(e[31:0]));
        check("card_idle at cmd", 64'(idle_a), 64'(e[38]));
      end
    end
    if (ferr_a) n_ferr++;
  end

  // R1 receiver: a byte starts at the first 0 bit the host samples
  bit       inb[2];
  logic [7:0] sh[2];
  int       nb[2];
  int       seen_epoch = 0;

  always @(posedge sd_clk) begin
    logic       bt;
    logic [7:0] e;
    if (seen_epoch != rst_epoch) begin
      seen_epoch = rst_epoch;
      inb[0] = 1'b0;
      inb[1] = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      bt = (c == 0) ? miso_a : miso_b;
      if (inb[c] || !bt) begin
        if (!inb[c]) begin
          inb[c] = 1'b1;
          nb[c]  = 0;
          check(c == 0 ? "latency A" : "latency B", 64'(host_rises - end_rise),
                c == 0 ? 64'd9 : 64'd17);
        end
        sh[c] = {sh[c][6:0], bt};
        nb[c]++;
        if (nb[c] == 8) begin
          inb[c] = 1'b0;
          if (c == 0) begin
            if (q_a.size() == 0) check("unexpected R1 A", 64'(sh[c]), 64'h100);
            else begin e = q_a.pop_front(); check("R1 A", 64'(sh[c]), 64'(e)); end
          end else begin
            if (q_b.size() == 0) check("unexpected R1 B", 64'(sh[c]), 64'h100);
            else begin e = q_b.pop_front(); check("R1 B", 64'(sh[c]), 64'(e)); end
          end
        end
      end
    end
  end

  task automatic sbit(input logic m);
    sd_mosi = m;
    #HALF;
    host_rises++;
    sd_clk = 1'b1;
    #HALF;
    sd_clk = 1'b0;
  endtask

  task automatic read_bytes(input int n);
    for (int i = 0; i < 8 * n; i++) sbit(1'b1);
  endtask

  task automatic xfer(input logic [47:0] f, input bit resp, input logic idle_exp,
                      input logic [7:0] ra, input logic [7:0] rb);
    if (resp) begin
      q_cmd.push_back({idle_exp, f[45:40], f[39:8]});
      q_a.push_back(ra);
      q_b.push_back(rb);
    end
    sd_cs = 1'b0;
    #HALF;
    for (int i = 47; i >= 0; i--) sbit(f[i]);
    end_rise = host_rises;
    read_bytes(4);
    sd_mosi = 1'b1;
    #HALF;
    sd_cs = 1'b1;
    #(2 * HALF);
  endtask

  initial begin
    #(2ms);
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    #2ns;
    #50ns;
    reset_n = 1'b1;
    #20ns;
    check("reset MISO", 64'(miso_a), 64'd1);
    check("reset cmd_valid", 64'(valid_a), 64'd0);
    check("reset cmd_index", 64'(index_a), 64'd0);
    check("reset cmd_arg", 64'(arg_a), 64'd0);
    check("reset card_idle", 64'(idle_a), 64'd1);
    check("reset frame_err", 64'(ferr_a), 64'd0);

    xfer(48'h40_00000000_95, 1, 1'b1, 8'h01, 8'h01);
    xfer(48'h40_00000000_01, 1, 1'b1, 8'h09, 8'h01);
    xfer(48'h48_000001AA_87, 1, 1'b1, 8'h01, 8'h01);
    xfer(48'h77_00000000_65, 1, 1'b1, 8'h01, 8'h01);
    xfer(48'h69_40000000_77, 1, 1'b0, 8'h00, 8'h00);
    check("card_idle after ACMD41 A", 64'(idle_a), 64'd0);
    check("card_idle after ACMD41 B", 64'(idle_b), 64'd0);
    xfer(48'h51_00000000_55, 1, 1'b0, 8'h04, 8'h04);
    xfer(48'h69_40000000_77, 1, 1'b0, 8'h04, 8'h04);

    // CS abort after 20 bits of CMD0
    f = 48'h40_00000000_95;
    sd_cs = 1'b0;
    #HALF;
    for (int i = 47; i >= 28; i--) sbit(f[i]);
    sd_mosi = 1'b1;
    #HALF;
    sd_cs = 1'b1;
    #(2 * HALF);
    read_bytes(2);
    check("frame_err count after abort", 64'(n_ferr), 64'd1);
    check("MISO after abort", 64'(miso_a), 64'd1);
    xfer(48'h40_00000000_95, 1, 1'b1, 8'h01, 8'h01);

    xfer(48'h40_00000000_94, 0, 1'b1, 8'h00, 8'h00);
    check("frame_err count after bad end", 64'(n_ferr), 64'd2);

    // drive card A out of idle, then reset in the middle of a CMD8 R1
    xfer(48'h77_00000000_65, 1, 1'b1, 8'h01, 8'h01);
    xfer(48'h69_40000000_77, 1, 1'b0, 8'h00, 8'h00);
    f = 48'h48_000001AA_87;
    q_cmd.push_back({1'b0, f[45:40], f[39:8]});
    sd_cs = 1'b0;
    #HALF;
    for (int i = 47; i >= 0; i--) sbit(f[i]);
    end_rise = host_rises;
    for (int i = 0; i < 12; i++) sbit(1'b1);
    #30ns;
    reset_n = 1'b0;
    rst_epoch++;
    #1ns;
    check("MISO in reset A", 64'(miso_a), 64'd1);
    check("MISO in reset B", 64'(miso_b), 64'd1);
    check("card_idle in reset A", 64'(idle_a), 64'd1);
    check("card_idle in reset B", 64'(idle_b), 64'd1);
    check("cmd_index in reset", 64'(index_a), 64'd0);
    #20ns;
    reset_n = 1'b1;
    sd_cs = 1'b1;
    #(2 * HALF);
    xfer(48'h40_00000000_95, 1, 1'b1, 8'h01, 8'h01);

    #(4 * HALF);
    check("cmd queue drained", 64'(q_cmd.size()), 64'd0);
    check("R1 A queue drained", 64'(q_a.size()), 64'd0);
    check("R1 B queue drained", 64'(q_b.size()), 64'd0);
    check("frame_err total", 64'(n_ferr), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
